dp_ram_fifo_ctrl: RTL and testbench

- Initiator-side controller for the team's dual-port RAM (dp_ram_rtl); drives its write and read ports and turns the RAM into a streaming FIFO.
- Upstream side: valid/ready push interface. Downstream side: valid/ready pop interface.
- Hides the RAM's 1-cycle registered read latency behind a 2-entry output buffer, so the FIFO sustains one word per cycle.
- Sits between a producer and a consumer. The top level instantiates dp_ram_rtl next to it and ties the RAM's rst_n_in to ~rst_in.

---
 rtl/dp_ram_fifo_pkg.sv | 14 +
 rtl/dp_ram_fifo_obuf.sv | 65 ++++++
 rtl/dp_ram_fifo_ctrl.sv | 97 +++++++++
 tb/tb_dp_ram_fifo_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dp_ram_fifo_pkg.sv
// Shared constants and width helpers for the dual-port-RAM-backed streaming FIFO.
package dp_ram_fifo_pkg;

    localparam int RAM_RD_LATENCY     = 1;
    localparam int OBUF_DEPTH         = 2;
    localparam int DEFAULT_ADDR_WIDTH = 8;
    localparam int DEFAULT_DATA_WIDTH = 32;

    // Level must count DEPTH words in the RAM plus the output buffer entries.
    function automatic int levelWidth(input int addrWidth);
        return addrWidth + 2;
    endfunction

endpackage

// File: rtl/dp_ram_fifo_obuf.sv
// Two-entry output skid buffer; entry 0 is the FIFO head presented downstream.
module dp_ram_fifo_obuf
    import dp_ram_fifo_pkg::*;
#(
    parameter int data_width = DEFAULT_DATA_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_capture,
    input  logic [data_width-1:0] i_captureData,
    input  logic                  i_pop,
    output logic [data_width-1:0] o_headData,
    output logic                  o_valid,
    output logic [1:0]            o_count
);

    logic [data_width-1:0] r_entry0;
    logic [data_width-1:0] r_entry1;
    logic [1:0]            r_count;

    // A capture arriving with a pop slots in behind the shifted head, keeping order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_entry0 <= '0;
            r_entry1 <= '0;
            r_count  <= 2'd0;
        end else begin
            case (r_count)
                2'd0: begin
                    if (i_capture) begin
                        r_entry0 <= i_captureData;
                        r_count  <= 2'd1;
                    end
                end
                2'd1: begin
                    case ({i_pop, i_capture})
                        2'b11: r_entry0 <= i_captureData;
                        2'b10: r_count  <= 2'd0;
                        2'b01: begin
                            r_entry1 <= i_captureData;
                            r_count  <= 2'd2;
                        end
                        default: ;
                    endcase
                end
                2'd2: begin
                    if (i_pop) begin
                        r_entry0 <= r_entry1;
                        if (i_capture) begin
                            r_entry1 <= i_captureData;
                        end else begin
                            r_count <= 2'd1;
                        end
                    end
                end
                default: r_count <= 2'd0;
            endcase
        end
    end

    assign o_headData = r_entry0;
    assign o_valid    = (r_count != 2'd0);
    assign o_count    = r_count;

endmodule

// File: rtl/dp_ram_fifo_ctrl.sv
// Initiator-side controller that turns a dual-port RAM with 1-cycle read latency
// into a valid/ready streaming FIFO sustaining one word per cycle.
module dp_ram_fifo_ctrl
    import dp_ram_fifo_pkg::*;
#(
    parameter int addr_width = DEFAULT_ADDR_WIDTH,
    parameter int data_width = DEFAULT_DATA_WIDTH
) (
    input  logic                              clk_in,
    input  logic                              rst_in,
    input  logic [data_width-1:0]             s_data_in,
    input  logic                              s_valid_in,
    output logic                              s_ready_out,
    output logic [data_width-1:0]             m_data_out,
    output logic                              m_valid_out,
    input  logic                              m_ready_in,
    output logic                              ram_wr_en_out,
    output logic [addr_width-1:0]             ram_wr_addr_out,
    output logic [data_width-1:0]             ram_wr_data_out,
    output logic                              ram_rd_en_out,
    output logic [addr_width-1:0]             ram_rd_addr_out,
    input  logic [data_width-1:0]             ram_rd_data_in,
    output logic [levelWidth(addr_width)-1:0] level_out
);

    localparam int LW = levelWidth(addr_width);
    localparam logic [addr_width:0] FULL_COUNT = {1'b1, {addr_width{1'b0}}};

    logic [addr_width-1:0] r_wrPtr;
    logic [addr_width-1:0] r_rdPtr;
    logic [addr_width:0]   r_ramCount;
    logic                  r_inflight;
    logic [LW-1:0]         r_level;

    logic                  w_pushFire;
    logic                  w_popFire;
    logic                  w_rdIssue;
    logic [1:0]            w_obufCount;
    logic [2:0]            w_occupancy;

    assign s_ready_out = ~rst_in & (r_ramCount < FULL_COUNT);
    assign w_pushFire  = s_valid_in & s_ready_out;
    assign w_popFire   = m_valid_out & m_ready_in;

    // Only fetch when the word will have a free output-buffer slot on arrival.
    assign w_occupancy = {1'b0, w_obufCount} + {2'b00, r_inflight} - {2'b00, w_popFire};
    assign w_rdIssue   = (r_ramCount != '0) & (w_occupancy < 3'd2);

    assign ram_wr_en_out   = w_pushFire;
    assign ram_wr_addr_out = r_wrPtr;
    assign ram_wr_data_out = w_pushFire ? s_data_in : '0;
    assign ram_rd_en_out   = w_rdIssue;
    assign ram_rd_addr_out = r_rdPtr;
    assign level_out       = r_level;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_ramCount <= '0;
            r_inflight <= 1'b0;
            r_level    <= '0;
        end else begin
            if (w_pushFire) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_rdIssue) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            r_inflight <= w_rdIssue;
            case ({w_pushFire, w_rdIssue})
                2'b10:   r_ramCount <= r_ramCount + 1'b1;
                2'b01:   r_ramCount <= r_ramCount - 1'b1;
                default: r_ramCount <= r_ramCount;
            endcase
            case ({w_pushFire, w_popFire})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    dp_ram_fifo_obuf #(
        .data_width(data_width)
    ) u_obuf (
        .i_clk        (clk_in),
        .i_rst        (rst_in),
        .i_capture    (r_inflight),
        .i_captureData(ram_rd_data_in),
        .i_pop        (w_popFire),
        .o_headData   (m_data_out),
        .o_valid      (m_valid_out),
        .o_count      (w_obufCount)
    );

endmodule

// File: tb/tb_dp_ram_fifo_ctrl.sv
// Directed bench for dp_ram_fifo_ctrl with a behavioural dual-port RAM alongside.
module tb_dp_ram_fifo_ctrl;

    localparam int AW    = 8;
    localparam int DW    = 32;
    localparam int DEPTH = 256;

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b1;
    logic [DW-1:0] s_data_in = '0;
    logic          s_valid_in = 1'b0;
    logic          s_ready_out;
    logic [DW-1:0] m_data_out;
    logic          m_valid_out;
    logic          m_ready_in = 1'b0;
    logic          ram_wr_en_out;
    logic [AW-1:0] ram_wr_addr_out;
    logic [DW-1:0] ram_wr_data_out;
    logic          ram_rd_en_out;
    logic [AW-1:0] ram_rd_addr_out;
    logic [DW-1:0] ram_rd_data_in = '0;
    logic [AW+1:0] level_out;

    logic [DW-1:0] ramMem [DEPTH];

    int tests = 0;
    int fails = 0;
    int benchCount = 0;
    int wrWrap255 = 0;

    always #5 clk_in = ~clk_in;

    dp_ram_fifo_ctrl #(.addr_width(AW), .data_width(DW)) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .s_data_in      (s_data_in),
        .s_valid_in     (s_valid_in),
        .s_ready_out    (s_ready_out),
        .m_data_out     (m_data_out),
        .m_valid_out    (m_valid_out),
        .m_ready_in     (m_ready_in),
        .ram_wr_en_out  (ram_wr_en_out),
        .ram_wr_addr_out(ram_wr_addr_out),
        .ram_wr_data_out(ram_wr_data_out),
        .ram_rd_en_out  (ram_rd_en_out),
        .ram_rd_addr_out(ram_rd_addr_out),
        .ram_rd_data_in (ram_rd_data_in),
        .level_out      (level_out)
    );

    // Registered-read dual-port RAM, matching dp_ram_rtl timing.
    always @(posedge clk_in) begin
        if (ram_wr_en_out) ramMem[ram_wr_addr_out] <= ram_wr_data_out;
        if (ram_rd_en_out) ram_rd_data_in <= ramMem[ram_rd_addr_out];
    end

    // Sampled just before each rising edge: RAM occupancy and output-buffer invariants.
    always begin
        @(negedge clk_in);
        #4;
        if (rst_in) begin
            benchCount = 0;
        end else begin
            tests++;
            if (int'(dut.w_obufCount) + int'(dut.r_inflight) > 2) begin
                fails++;
                $display("[TB] FAIL obuf_invariant: occupancy=%0d required<=2",
                         int'(dut.w_obufCount) + int'(dut.r_inflight));
            end
            if (ram_wr_en_out) begin
                tests++;
                if (benchCount >= DEPTH) begin
                    fails++;
                    $display("[TB] FAIL push_when_full: ram words=%0d", benchCount);
                end
                if (ram_wr_addr_out == 8'd255) wrWrap255++;
            end
            if (ram_rd_en_out) begin
                tests++;
                if (benchCount == 0) begin
                    fails++;
                    $display("[TB] FAIL read_when_empty: ram words=%0d", benchCount);
                end
            end
            benchCount = benchCount + int'(ram_wr_en_out) - int'(ram_rd_en_out);
        end
    end

    task automatic test_reset();
        rst_in = 1'b1; s_valid_in = 1'b0; m_ready_in = 1'b0;
        @(negedge clk_in); @(negedge clk_in); #1;
        tests++;
        if (s_ready_out !== 1'b0) begin
            fails++; $display("[TB] FAIL reset_ready_forced: got %b want 0", s_ready_out);
        end
        @(negedge clk_in);
        rst_in = 1'b0; #1;
        tests++;
        if (s_ready_out !== 1'b1 || m_valid_out !== 1'b0 || level_out !== '0 ||
            ram_wr_en_out !== 1'b0 || ram_rd_en_out !== 1'b0 || m_data_out !== '0) begin
            fails++;
            $display("[TB] FAIL reset_state: rdy=%b mv=%b lvl=%0d we=%b re=%b md=%0h want 1 0 0 0 0 0",
                     s_ready_out, m_valid_out, level_out, ram_wr_en_out, ram_rd_en_out, m_data_out);
        end
    endtask

    task automatic test_single_word();
        @(negedge clk_in);
        m_ready_in = 1'b0; s_valid_in = 1'b1; s_data_in = 32'd225; #1;
        tests++;
        if (ram_wr_en_out !== 1'b1 || ram_wr_addr_out !== 8'd0 || ram_wr_data_out !== 32'd225) begin
            fails++;
            $display("[TB] FAIL single_write: we=%b addr=%0d data=%0d want 1 0 225",
                     ram_wr_en_out, ram_wr_addr_out, ram_wr_data_out);
        end
        @(negedge clk_in);
        s_valid_in = 1'b0; #1;
        tests++;
        if (ram_rd_en_out !== 1'b1 || ram_rd_addr_out !== 8'd0 || m_valid_out !== 1'b0 || level_out !== 10'd1) begin
            fails++;
            $display("[TB] FAIL single_read_issue: re=%b addr=%0d mv=%b lvl=%0d want 1 0 0 1",
                     ram_rd_en_out, ram_rd_addr_out, m_valid_out, level_out);
        end
        @(negedge clk_in); #1;
        tests++;
        if (m_valid_out !== 1'b0 || ram_rd_en_out !== 1'b0) begin
            fails++;
            $display("[TB] FAIL single_latency: mv=%b re=%b want 0 0", m_valid_out, ram_rd_en_out);
        end
        @(negedge clk_in); #1;
        tests++;
        if (m_valid_out !== 1'b1 || m_data_out !== 32'd225 || level_out !== 10'd1) begin
            fails++;
            $display("[TB] FAIL single_output: mv=%b data=%0d lvl=%0d want 1 225 1",
                     m_valid_out, m_data_out, level_out);
        end
        @(negedge clk_in); @(negedge clk_in); #1;
        tests++;
        if (m_valid_out !== 1'b1 || m_data_out !== 32'd225) begin
            fails++;
            $display("[TB] FAIL single_hold: mv=%b data=%0d want 1 225", m_valid_out, m_data_out);
        end
        m_ready_in = 1'b1;
        @(negedge clk_in);
        m_ready_in = 1'b0; #1;
        tests++;
        if (m_valid_out !== 1'b0 || level_out !== 10'd0) begin
            fails++;
            $display("[TB] FAIL single_pop: mv=%b lvl=%0d want 0 0", m_valid_out, level_out);
        end
    endtask

    task automatic test_fill();
        int notReady = 0;
        int bad = 0;
        int expVal = 0;
        int cyc = 0;
        m_ready_in = 1'b0;
        for (int i = 0; i < 258; i++) begin
            @(negedge clk_in);
            s_valid_in = 1'b1; s_data_in = DW'(i); #1;
            if (s_ready_out !== 1'b1) notReady++;
        end
        tests++;
        if (notReady != 0) begin
            fails++; $display("[TB] FAIL fill_accept: stalled=%0d want 0", notReady);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_in);
            s_valid_in = 1'b1; s_data_in = 32'hDEAD; #1;
            tests++;
            if (s_ready_out !== 1'b0 || ram_wr_en_out !== 1'b0 || level_out !== 10'd258) begin
                fails++;
                $display("[TB] FAIL fill_full: rdy=%b we=%b lvl=%0d want 0 0 258",
                         s_ready_out, ram_wr_en_out, level_out);
            end
        end
        s_valid_in = 1'b0; m_ready_in = 1'b1;
        while (expVal < 258 && cyc < 1000) begin
            if (m_valid_out === 1'b1) begin
                if (m_data_out !== DW'(expVal)) bad++;
                expVal++;
            end
            @(negedge clk_in); #1;
            cyc++;
        end
        m_ready_in = 1'b0;
        tests++;
        if (expVal != 258 || bad != 0 || level_out !== 10'd0) begin
            fails++;
            $display("[TB] FAIL fill_drain: popped=%0d wrong=%0d lvl=%0d want 258 0 0", expVal, bad, level_out);
        end
    endtask

    task automatic test_streaming();
        int nextPush = 1;
        int expPop = 1;
        int bad = 0;
        int firstCyc = -1;
        int lastCyc = -1;
        wrWrap255 = 0;
        m_ready_in = 1'b1;
        @(negedge clk_in);
        for (int cyc = 0; cyc < 3000 && expPop <= 1000; cyc++) begin
            s_valid_in = (nextPush <= 1000);
            s_data_in = DW'(nextPush); #1;
            if (s_valid_in && s_ready_out) nextPush++;
            if (m_valid_out === 1'b1) begin
                if (m_data_out !== DW'(expPop)) bad++;
                expPop++;
                if (firstCyc < 0) firstCyc = cyc;
                lastCyc = cyc;
            end
            @(negedge clk_in);
        end
        s_valid_in = 1'b0; m_ready_in = 1'b0;
        tests++;
        if (expPop != 1001 || bad != 0) begin
            fails++; $display("[TB] FAIL stream_order: popped=%0d wrong=%0d want 1000 0", expPop - 1, bad);
        end
        tests++;
        if (firstCyc != 3 || lastCyc - firstCyc != 999) begin
            fails++;
            $display("[TB] FAIL stream_rate: first=%0d span=%0d want 3 999", firstCyc, lastCyc - firstCyc);
        end
        tests++;
        if (wrWrap255 < 3) begin
            fails++; $display("[TB] FAIL stream_wrap: wraps=%0d want>=3", wrWrap255);
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] sb[$];
        logic [DW-1:0] expWord;
        int pushed = 0;
        int popped = 0;
        int bad = 0;
        logic toggle = 1'b0;
        @(negedge clk_in);
        for (int cyc = 0; cyc < 5000 && popped < 500; cyc++) begin
            toggle = ~toggle;
            m_ready_in = toggle;
            s_valid_in = (pushed < 500) && ($urandom_range(0, 1) == 1);
            s_data_in = DW'($urandom); #1;
            if (m_valid_out === 1'b1 && m_ready_in) begin
                if (sb.size() == 0) begin
                    bad++;
                end else begin
                    expWord = sb.pop_front();
                    if (m_data_out !== expWord) bad++;
                end
                popped++;
            end
            if (s_valid_in && s_ready_out) begin
                sb.push_back(s_data_in);
                pushed++;
            end
            @(negedge clk_in);
        end
        s_valid_in = 1'b0; m_ready_in = 1'b0; #1;
        tests++;
        if (popped != 500 || bad != 0 || sb.size() != 0 || level_out !== 10'd0) begin
            fails++;
            $display("[TB] FAIL backpressure: popped=%0d wrong=%0d left=%0d lvl=%0d want 500 0 0 0",
                     popped, bad, sb.size(), level_out);
        end
    endtask

    task automatic test_mid_reset();
        int cyc = 0;
        m_ready_in = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_in);
            s_valid_in = 1'b1; s_data_in = DW'(100 + i);
        end
        @(negedge clk_in);
        s_valid_in = 1'b0;
        repeat (3) @(negedge clk_in);
        #1;
        tests++;
        if (level_out !== 10'd10 || m_valid_out !== 1'b1 || m_data_out !== 32'd100) begin
            fails++;
            $display("[TB] FAIL midrst_stored: lvl=%0d mv=%b data=%0d want 10 1 100",
                     level_out, m_valid_out, m_data_out);
        end
        @(negedge clk_in);
        m_ready_in = 1'b1; rst_in = 1'b1; #1;
        tests++;
        if (ram_rd_en_out !== 1'b1) begin
            fails++; $display("[TB] FAIL midrst_read_active: re=%b want 1", ram_rd_en_out);
        end
        @(negedge clk_in);
        rst_in = 1'b0; m_ready_in = 1'b0;
        s_valid_in = 1'b1; s_data_in = 32'hA5; #1;
        tests++;
        if (m_valid_out !== 1'b0 || level_out !== 10'd0) begin
            fails++;
            $display("[TB] FAIL midrst_cleared: mv=%b lvl=%0d want 0 0", m_valid_out, level_out);
        end
        @(negedge clk_in);
        s_valid_in = 1'b0; #1;
        tests++;
        if (m_valid_out !== 1'b0) begin
            fails++; $display("[TB] FAIL midrst_stale: mv=%b data=%0h want 0", m_valid_out, m_data_out);
        end
        m_ready_in = 1'b1;
        while (m_valid_out !== 1'b1 && cyc < 20) begin
            @(negedge clk_in); #1;
            cyc++;
        end
        tests++;
        if (m_valid_out !== 1'b1 || m_data_out !== 32'hA5) begin
            fails++;
            $display("[TB] FAIL midrst_first_word: mv=%b data=%0h want 1 a5", m_valid_out, m_data_out);
        end
        @(negedge clk_in);
        m_ready_in = 1'b0; #1;
        tests++;
        if (m_valid_out !== 1'b0 || level_out !== 10'd0) begin
            fails++;
            $display("[TB] FAIL midrst_drain: mv=%b lvl=%0d want 0 0", m_valid_out, level_out);
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_fill();
        test_streaming();
        test_backpressure();
        test_mid_reset();
        repeat (2) @(negedge clk_in);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
